// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

endpackage

// File: rtl/mux_scan_sequencer_chan_next.sv
// Combinational channel picker: next enabled channel above the current select,
// and lowest enabled channel of the mask presented at frame start.
module chan_next
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [NUM_CH-1:0] i_start_mask,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_found,
    output logic [SEL_W-1:0]  o_lowest
);

    // Scan downwards so the last hit is the closest enabled index above i_sel
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_sel))) begin
                o_next  = SEL_W'(i);
                o_found = 1'b1;
            end
        end
    end

    // Scan downwards so the last hit is the lowest enabled index
    always_comb begin
        o_lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_start_mask[i]) begin
                o_lowest = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: steps the 4:1 mux select over the enabled channels,
// waits a programmable settle time on each, samples y and assembles a frame.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               continuous,
    input  logic [NUM_CH-1:0]  chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_y,
    output logic [SEL_W-1:0]   sel,
    output logic               sample_valid,
    output logic [NUM_CH-1:0]  frame,
    output logic               frame_valid,
    output logic               busy
);

    state_e             r_state, w_state_d;
    logic [NUM_CH-1:0]  r_mask, w_mask_d;
    logic [NUM_CH-1:0]  r_shadow, w_shadow_d;
    logic [NUM_CH-1:0]  r_frame, w_frame_d;
    logic [DWELL_W-1:0] r_dwell, w_dwell_d;
    logic [DWELL_W-1:0] r_cnt, w_cnt_d;
    logic [SEL_W-1:0]   r_sel, w_sel_d;
    logic [SEL_W-1:0]   w_next, w_lowest;
    logic               w_found;
    logic               w_launch;

    chan_next u_chan_next (
        .i_mask       (r_mask),
        .i_sel        (r_sel),
        .i_start_mask (chan_mask),
        .o_next       (w_next),
        .o_found      (w_found),
        .o_lowest     (w_lowest)
    );

    // State and datapath registers; ena low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_mask   <= '0;
            r_shadow <= '0;
            r_frame  <= '0;
            r_dwell  <= '0;
            r_cnt    <= '0;
            r_sel    <= '0;
        end else if (ena) begin
            r_state  <= w_state_d;
            r_mask   <= w_mask_d;
            r_shadow <= w_shadow_d;
            r_frame  <= w_frame_d;
            r_dwell  <= w_dwell_d;
            r_cnt    <= w_cnt_d;
            r_sel    <= w_sel_d;
        end
    end

    // Next-state logic; a frame launch (from IDLE or DONE) overrides the defaults
    always_comb begin
        w_state_d  = r_state;
        w_mask_d   = r_mask;
        w_shadow_d = r_shadow;
        w_frame_d  = r_frame;
        w_dwell_d  = r_dwell;
        w_cnt_d    = r_cnt;
        w_sel_d    = r_sel;
        w_launch   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start && (chan_mask != '0)) begin
                    w_launch = 1'b1;
                end
            end
            StSettle: begin
                if (r_cnt == '0) begin
                    w_state_d = StSample;
                end else begin
                    w_cnt_d = r_cnt - DWELL_W'(1);
                end
            end
            StSample: begin
                w_shadow_d[r_sel] = mux_y;
                if (w_found) begin
                    w_sel_d   = w_next;
                    w_cnt_d   = r_dwell;
                    w_state_d = StSettle;
                end else begin
                    // Merge the final sample directly so frame is complete in DONE
                    w_frame_d        = r_shadow;
                    w_frame_d[r_sel] = mux_y;
                    w_state_d        = StDone;
                end
            end
            StDone: begin
                if (continuous && (chan_mask != '0)) begin
                    w_launch = 1'b1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_launch) begin
            w_mask_d   = chan_mask;
            w_dwell_d  = dwell;
            w_shadow_d = '0;
            w_sel_d    = w_lowest;
            w_cnt_d    = dwell;
            w_state_d  = StSettle;
        end
    end

    assign sel          = r_sel;
    assign frame        = r_frame;
    assign busy         = (r_state != StIdle);
    assign sample_valid = ena && (r_state == StSample);
    assign frame_valid  = ena && (r_state == StDone);

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Upstream control stage for the 4:1 channel multiplexer in the top-level design.
- Drives the mux select, stepping through an enabled subset of the four channels (a, b, c, d), with a programmable settle time per channel.
- Samples the mux output bit `y` back on each visit and assembles the four samples into a frame word.
- Supports single-shot and continuous scanning.

## Interface
Parameters:
- `DWELL_W`, default 4: width of the settle-count input.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `ena`  in  1  clock enable; low freezes all state, and `sample_valid`/`frame_valid` read 0
- `start`  in  1  begins a scan when in IDLE; ignored otherwise
- `continuous`  in  1  sampled in DONE: 1 starts the next frame immediately, 0 returns to IDLE
- `chan_mask`  in  4  bit i enables channel i (0=a, 1=b, 2=c, 3=d)
- `dwell`  in  DWELL_W  settle cycles minus one per channel
- `mux_y`  in  1  mux output bit `y`
- `sel`  out  2  mux select `s[1:0]`
- `sample_valid`  out  1  high during the SAMPLE cycle
- `frame`  out  4  last completed frame; bit i = sample of channel i, 0 if channel not enabled
- `frame_valid`  out  1  one-cycle pulse; `frame` has just been updated
- `busy`  out  1  high in any state other than IDLE

## Operation
States: IDLE, SETTLE, SAMPLE, DONE.

Registers:
- `mask_q` and `dwell_q` are latched on each frame start and stay constant for the whole frame.
- `shadow` holds the in-progress samples.
- `cnt` is the SETTLE down-counter.

Transitions:
- **IDLE:** if `start` and `chan_mask != 0`, do all of the following on one edge, then go to SETTLE:
  - latch `mask_q` and `dwell_q`;
  - clear `shadow`;
  - set `sel` to the lowest enabled index;
  - set `cnt = dwell`.
- **IDLE, `start` with `chan_mask == 0`:** no effect; stay in IDLE.
- **SETTLE:** if `cnt == 0`, go to SAMPLE; otherwise decrement `cnt`. SETTLE therefore lasts `dwell+1` cycles.
- **SAMPLE:** one cycle. On the exiting edge:
  - write `shadow[sel] <= mux_y`;
  - if a higher enabled index exists in `mask_q`, set `sel` to it, reload `cnt = dwell_q`, and go to SETTLE;
  - otherwise load `frame` from `shadow` with the new sample merged in, and go to DONE.
- **DONE:** one cycle; `frame_valid` is high.
  - If `continuous` is high and `chan_mask != 0`: relatch mask and dwell, clear `shadow`, select the lowest enabled channel, and go to SETTLE.
  - Otherwise go to IDLE.
- `start` is ignored in all states other than IDLE.
- Changing `chan_mask` or `dwell` mid-frame has no effect until the next frame start.
- `sel` holds its value while in IDLE and in DONE (until it is reloaded).

## Timing
- **Reset:** asynchronous, immediate, from any state. All outputs go to 0; state goes to IDLE; `shadow`, `cnt`, `mask_q` and `dwell_q` are cleared.
- **Counting convention:** the `start` edge is E0; cycle k is the cycle after edge Ek. N = popcount(mask).
- **Per-channel cost:** `dwell+2` cycles (SETTLE plus SAMPLE).
- **Frame completion:** `frame_valid` is high in cycle N·(dwell+2)+1.
- **Continuous mode:** `frame_valid` pulses repeat every N·(dwell+2)+1 cycles.
- **Select stability:** `sel` is stable for the full `dwell+2` cycles of each channel. `mux_y` only has to be valid during SAMPLE.
- **`ena` low:** freezes the state machine and every register for the duration; timelines stretch by exactly the number of frozen cycles.

## Structure
- Package `mux_scan_pkg`: state enum, `NUM_CH = 4`, `SEL_W = 2`.
- Sub-module `chan_next`: purely combinational. Given `mask_q` and the current `sel`, it returns the next higher enabled index and a found flag. It also returns the lowest enabled index, used for frame start.
- The top level wires `sel` to the mux select and the mux `y` to `mux_y`.

## Test plan
- **Full mask:** `mask=1111`, `dwell=0`, and a=1, b=0, c=1, d=1.
  - `sel` reads 0,0,1,1,2,2,3,3 over cycles 1-8.
  - `frame_valid` is high in cycle 9 with `frame=4'b1101`; then IDLE.
- **Partial mask:** `mask=1010`, `dwell=3`, b=1, d=1.
  - `sel=1` for cycles 1-5, then `sel=3` for cycles 6-10.
  - `frame_valid` is high in cycle 11 with `frame=4'b1010`.
- **Empty mask:** `start` with `mask=0000`. `busy`, `sel` and `frame` stay 0 and there is no `frame_valid`.
- **Continuous mode:** `continuous=1`, `mask=1111`, `dwell=1`, with `start` pulses issued while busy.
  - `frame_valid` pulses every 13 cycles.
  - The extra `start` pulses have no effect.
  - Deasserting `continuous` ends scanning after the current frame.
- **Freeze:** `ena=0` for 3 cycles during SETTLE. The `frame_valid` cycle shifts by exactly 3.
- **Reset mid-scan:** assert `rst_n` during SAMPLE. All outputs read 0 immediately; a new `start` runs a clean frame.
